// File: rtl/store_pack_if.sv
// store_pack_if
//   Bundles the store request channel, the flush line, the formatted
//   memory-side channel and the AdES exception outputs of store_pack.
//
//   Request side : req_valid, req_ready, req_op[1:0], req_addr[31:0],
//                  req_data[31:0], flush
//   Memory side  : m_valid, m_ready, m_addr[31:0], m_byteen[3:0],
//                  m_wdata[31:0]
//   Exception    : exc_valid, exc_code[4:0], exc_badvaddr[31:0]
//
//   slave  : the store_pack view (consumes requests, produces stores)
//   master : the surrounding pipeline / memory view
interface store_pack_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [3:0]  m_byteen;
  logic [31:0] m_wdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;

  modport slave (
    input  req_valid, req_op, req_addr, req_data, flush, m_ready,
    output req_ready, m_valid, m_addr, m_byteen, m_wdata,
           exc_valid, exc_code, exc_badvaddr
  );

  modport master (
    output req_valid, req_op, req_addr, req_data, flush, m_ready,
    input  req_ready, m_valid, m_addr, m_byteen, m_wdata,
           exc_valid, exc_code, exc_badvaddr
  );
endinterface

// File: rtl/store_pack.sv
// store_pack
//   Formats sw/sh/sb store requests into a word address, byte-lane enables
//   and lane-replicated write data, held in a single output register toward
//   memory. Illegal stores (misaligned, unmapped, sub-word to a timer, or
//   writes to a timer COUNT register) are consumed and raise a one-cycle
//   AdES exception instead of reaching memory.
//
//   Ports:
//     clk   : sole clock, rising edge
//     reset : synchronous active-high reset
//     bus   : store_pack_if.slave (request, flush, memory, exception)
module store_pack (
  input  logic         clk,
  input  logic         reset,
  store_pack_if.slave  bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;

  state_t      state_q, state_d;
  logic        load, raise_exc, accept, legal;
  logic        in_dm, in_tc0, in_tc1, in_ig, in_tc, misaligned, is_count;
  logic [3:0]  byteen_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] addr_q, wdata_q, badvaddr_q;
  logic [3:0]  byteen_q;
  logic        exc_q;

  // The register can take a new store while its current one drains.
  assign bus.m_valid   = (state_q == FULL);
  assign bus.req_ready = !bus.m_valid || bus.m_ready;
  assign accept        = bus.req_valid && bus.req_ready && !bus.flush;

  // Address decode and legality; COUNT sits at offset 8..11 of either timer.
  always_comb begin
    in_dm      = (bus.req_addr <= 32'h0000_2FFF);
    in_tc0     = (bus.req_addr >= 32'h0000_7F00) && (bus.req_addr <= 32'h0000_7F0B);
    in_tc1     = (bus.req_addr >= 32'h0000_7F10) && (bus.req_addr <= 32'h0000_7F1B);
    in_ig      = (bus.req_addr >= 32'h0000_7F20) && (bus.req_addr <= 32'h0000_7F23);
    in_tc      = in_tc0 || in_tc1;
    is_count   = in_tc && (bus.req_addr[3:2] == 2'b10);
    misaligned = ((bus.req_op == OP_SW) && (bus.req_addr[1:0] != 2'b00)) ||
                 ((bus.req_op == OP_SH) && bus.req_addr[0]);
    legal      = (bus.req_op != 2'b11) && !misaligned &&
                 (in_dm || in_tc || in_ig) &&
                 !(in_tc && (bus.req_op != OP_SW)) && !is_count;
  end

  // Lane placement and replication of the store data.
  always_comb begin
    byteen_fmt = 4'b0000;
    wdata_fmt  = 32'h0;
    case (bus.req_op)
      OP_SW: begin
        byteen_fmt = 4'b1111;
        wdata_fmt  = bus.req_data;
      end
      OP_SH: begin
        byteen_fmt = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_fmt  = {2{bus.req_data[15:0]}};
      end
      OP_SB: begin
        byteen_fmt = 4'b0001 << bus.req_addr[1:0];
        wdata_fmt  = {4{bus.req_data[7:0]}};
      end
      default: begin
        byteen_fmt = 4'b0000;
        wdata_fmt  = 32'h0;
      end
    endcase
  end

  // Next state: a legal accept (re)loads the register; otherwise a flush
  // or a completed transfer empties it. Illegal accepts leave the
  // register untouched and only raise the exception.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    raise_exc = 1'b0;
    if (accept && legal) begin
      state_d = FULL;
      load    = 1'b1;
    end else begin
      raise_exc = accept;
      if (bus.flush || bus.m_ready) begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= 32'h0;
      byteen_q   <= 4'b0000;
      wdata_q    <= 32'h0;
      exc_q      <= 1'b0;
      badvaddr_q <= 32'h0;
    end else begin
      if (load) begin
        addr_q   <= {bus.req_addr[31:2], 2'b00};
        byteen_q <= byteen_fmt;
        wdata_q  <= wdata_fmt;
      end
      exc_q <= raise_exc;
      if (raise_exc) begin
        badvaddr_q <= bus.req_addr;
      end
    end
  end

  assign bus.m_addr       = addr_q;
  assign bus.m_byteen     = byteen_q;
  assign bus.m_wdata      = wdata_q;
  assign bus.exc_valid    = exc_q;
  assign bus.exc_code     = exc_q ? 5'd5 : 5'd0;
  assign bus.exc_badvaddr = badvaddr_q;

endmodule

// File: tb/tb_store_pack.sv
// tb_store_pack
//   Self-checking bench for store_pack: a behavioural model built from the
//   region table and byte-lane arithmetic predicts every output each cycle,
//   and directed scenarios add hand-computed literal expectations.
module tb_store_pack;

  logic clk = 1'b0;
  logic reset;
  store_pack_if bus ();

  store_pack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;
  bit cmp_en     = 1'b0;

  // Model state
  bit          exp_mv   = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [3:0]  exp_be   = 4'h0;
  logic [31:0] exp_wd   = 32'h0;
  bit          exp_exc  = 1'b0;
  logic [31:0] exp_bad  = 32'h0;

  // Address map: base, size, and whether the region is a timer
  localparam int unsigned RBASE [4] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10, 32'h0000_7F20};
  localparam int unsigned RSIZE [4] = '{32'h0000_3000, 12, 12, 4};
  localparam bit          RTIMER[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  function automatic int unsigned access_size(input logic [1:0] op);
    if (op == 2'd0) return 4;
    if (op == 2'd1) return 2;
    return 1;
  endfunction

  function automatic bit model_legal(input logic [1:0] op, input logic [31:0] a);
    int region = -1;
    int unsigned sz;
    int unsigned ua = a;
    if (op == 2'd3) return 1'b0;
    sz = access_size(op);
    if ((ua % sz) != 0) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ua >= RBASE[i] && ua < RBASE[i] + RSIZE[i]) region = i;
    end
    if (region < 0) return 1'b0;
    if (RTIMER[region]) begin
      if (sz != 4) return 1'b0;
      if ((ua - RBASE[region]) >= 8 && (ua - RBASE[region]) < 12) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_format(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] d,
                                       output logic [3:0] be, output logic [31:0] wd);
    int unsigned sz    = access_size(op);
    int unsigned start = ((a % 4) / sz) * sz;
    be = 4'h0;
    wd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= start && i < start + sz) be[i] = 1'b1;
      wd[8*i +: 8] = d[8*(i % sz) +: 8];
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    bit ready, acc;
    logic [3:0]  be;
    logic [31:0] wd;
    if (reset) begin
      exp_mv = 0; exp_addr = 0; exp_be = 0; exp_wd = 0; exp_exc = 0; exp_bad = 0;
    end else begin
      ready   = !exp_mv || bus.m_ready;
      acc     = bus.req_valid && ready && !bus.flush;
      exp_exc = 1'b0;
      if (acc && model_legal(bus.req_op, bus.req_addr)) begin
        exp_mv   = 1'b1;
        exp_addr = bus.req_addr & 32'hFFFF_FFFC;
        model_format(bus.req_op, bus.req_addr, bus.req_data, be, wd);
        exp_be = be;
        exp_wd = wd;
      end else begin
        if (acc) begin
          exp_exc = 1'b1;
          exp_bad = bus.req_addr;
        end
        if (bus.flush || bus.m_ready) exp_mv = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    checkOutput("m_valid", {31'b0, bus.m_valid}, {31'b0, exp_mv});
    checkOutput("req_ready", {31'b0, bus.req_ready}, {31'b0, (!exp_mv || bus.m_ready)});
    checkOutput("exc_valid", {31'b0, bus.exc_valid}, {31'b0, exp_exc});
    checkOutput("exc_code", {27'b0, bus.exc_code}, exp_exc ? 32'd5 : 32'd0);
    checkOutput("exc_badvaddr", bus.exc_badvaddr, exp_bad);
    if (exp_mv) begin
      checkOutput("m_addr", bus.m_addr, exp_addr);
      checkOutput("m_byteen", {28'b0, bus.m_byteen}, {28'b0, exp_be});
      checkOutput("m_wdata", bus.m_wdata, exp_wd);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) compare_all();
  end

  task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] d, input bit mr, input bit fl);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.m_ready   = mr;
    bus.flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit mr);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, mr, 1'b0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    bit          legal;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    idle(1'b0);
    tick();
    cmp_en = 1'b1;
    tick();
    // Reset state
    checkOutput("rst_m_valid", {31'b0, bus.m_valid}, 32'd0);
    checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("rst_m_addr", bus.m_addr, 32'h0);
    checkOutput("rst_m_byteen", {28'b0, bus.m_byteen}, 32'h0);
    checkOutput("rst_m_wdata", bus.m_wdata, 32'h0);
    checkOutput("rst_exc_code", {27'b0, bus.exc_code}, 32'h0);
    checkOutput("rst_badvaddr", bus.exc_badvaddr, 32'h0);
    reset = 1'b0;
    tick();

    // sb to lane 3
    applyStimulus(1'b1, 2'd2, 32'h0000_0103, 32'h1234_56AB, 1'b1, 1'b0);
    tick();
    checkOutput("sb_m_valid", {31'b0, bus.m_valid}, 32'd1);
    checkOutput("sb_m_addr", bus.m_addr, 32'h0000_0100);
    checkOutput("sb_byteen", {28'b0, bus.m_byteen}, 32'b1000);
    checkOutput("sb_wdata", bus.m_wdata, 32'hABAB_ABAB);
    idle(1'b1);
    tick();

    // sh to upper half, stalled for three cycles with a competing request
    applyStimulus(1'b1, 2'd1, 32'h0000_0202, 32'hFFFF_BEEF, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd0, 32'h0000_0000, 32'h1111_1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sh_stall_byteen", {28'b0, bus.m_byteen}, 32'b1100);
      checkOutput("sh_stall_wdata", bus.m_wdata, 32'hBEEF_BEEF);
      checkOutput("sh_stall_ready", {31'b0, bus.req_ready}, 32'd0);
      tick();
    end
    idle(1'b1);
    checkOutput("sh_drain_ready", {31'b0, bus.req_ready}, 32'd1);
    tick();
    checkOutput("sh_drained", {31'b0, bus.m_valid}, 32'd0);

    // AdES on COUNT write, then on misaligned sh
    applyStimulus(1'b1, 2'd0, 32'h0000_7F08, 32'hDEAD_0001, 1'b1, 1'b0);
    tick();
    checkOutput("ades_cnt_valid", {31'b0, bus.exc_valid}, 32'd1);
    checkOutput("ades_cnt_code", {27'b0, bus.exc_code}, 32'd5);
    checkOutput("ades_cnt_bad", bus.exc_badvaddr, 32'h0000_7F08);
    checkOutput("ades_cnt_mvalid", {31'b0, bus.m_valid}, 32'd0);
    applyStimulus(1'b1, 2'd1, 32'h0000_0001, 32'hDEAD_0002, 1'b1, 1'b0);
    tick();
    checkOutput("ades_sh_valid", {31'b0, bus.exc_valid}, 32'd1);
    checkOutput("ades_sh_bad", bus.exc_badvaddr, 32'h0000_0001);
    idle(1'b1);
    tick();
    checkOutput("ades_end_valid", {31'b0, bus.exc_valid}, 32'd0);
    checkOutput("ades_end_code", {27'b0, bus.exc_code}, 32'd0);
    checkOutput("ades_hold_bad", bus.exc_badvaddr, 32'h0000_0001);

    // Back-to-back sw with no bubble
    applyStimulus(1'b1, 2'd0, 32'h0000_0000, 32'hAAAA_0000, 1'b1, 1'b0);
    tick();
    checkOutput("b2b_first_valid", {31'b0, bus.m_valid}, 32'd1);
    checkOutput("b2b_first_addr", bus.m_addr, 32'h0000_0000);
    applyStimulus(1'b1, 2'd0, 32'h0000_0004, 32'hBBBB_0004, 1'b1, 1'b0);
    tick();
    checkOutput("b2b_second_valid", {31'b0, bus.m_valid}, 32'd1);
    checkOutput("b2b_second_addr", bus.m_addr, 32'h0000_0004);
    checkOutput("b2b_second_wdata", bus.m_wdata, 32'hBBBB_0004);
    idle(1'b1);
    tick();

    // Flush while stalled
    applyStimulus(1'b1, 2'd0, 32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("flush_stall_mvalid", {31'b0, bus.m_valid}, 32'd0);
    // Flush while transferring
    applyStimulus(1'b1, 2'd0, 32'h0000_0014, 32'h0000_0014, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    checkOutput("flush_xfer_seen", {31'b0, bus.m_valid & bus.m_ready}, 32'd1);
    tick();
    checkOutput("flush_xfer_empty", {31'b0, bus.m_valid}, 32'd0);
    // Requests presented with flush are dropped silently
    applyStimulus(1'b1, 2'd0, 32'h0000_0020, 32'h0000_0020, 1'b1, 1'b1);
    tick();
    checkOutput("flush_drop_mvalid", {31'b0, bus.m_valid}, 32'd0);
    applyStimulus(1'b1, 2'd0, 32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1);
    tick();
    checkOutput("flush_drop_exc", {31'b0, bus.exc_valid}, 32'd0);
    idle(1'b1);
    tick();

    // Reset mid-operation beats a concurrent accept
    applyStimulus(1'b1, 2'd0, 32'h0000_0040, 32'h4040_4040, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 2'd0, 32'h0000_0044, 32'h4444_4444, 1'b0, 1'b0);
    tick();
    checkOutput("midrst_mvalid", {31'b0, bus.m_valid}, 32'd0);
    checkOutput("midrst_addr", bus.m_addr, 32'h0);
    checkOutput("midrst_wdata", bus.m_wdata, 32'h0);
    checkOutput("midrst_ready", {31'b0, bus.req_ready}, 32'd1);
    reset = 1'b0;
    idle(1'b1);
    tick();

    // Region boundaries and illegal-store rules
    vecs.push_back('{2'd0, 32'h0000_2FFC, 1'b1});
    vecs.push_back('{2'd0, 32'h0000_3000, 1'b0});
    vecs.push_back('{2'd2, 32'h0000_2FFF, 1'b1});
    vecs.push_back('{2'd0, 32'h0000_7F00, 1'b1});
    vecs.push_back('{2'd0, 32'h0000_7F04, 1'b1});
    vecs.push_back('{2'd0, 32'h0000_7F08, 1'b0});
    vecs.push_back('{2'd2, 32'h0000_7F01, 1'b0});
    vecs.push_back('{2'd1, 32'h0000_7F12, 1'b0});
    vecs.push_back('{2'd0, 32'h0000_7F18, 1'b0});
    vecs.push_back('{2'd0, 32'h0000_7F14, 1'b1});
    vecs.push_back('{2'd0, 32'h0000_7F0C, 1'b0});
    vecs.push_back('{2'd2, 32'h0000_7F23, 1'b1});
    vecs.push_back('{2'd1, 32'h0000_7F22, 1'b1});
    vecs.push_back('{2'd0, 32'h0000_7F24, 1'b0});
    vecs.push_back('{2'd3, 32'h0000_0000, 1'b0});
    vecs.push_back('{2'd0, 32'h0000_0002, 1'b0});
    vecs.push_back('{2'd1, 32'h0000_0006, 1'b1});
    vecs.push_back('{2'd0, 32'hFFFF_FFFC, 1'b0});
    vecs.push_back('{2'd0, 32'h0001_0000, 1'b0});
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].addr, 32'hC0DE_0000 + i, 1'b1, 1'b0);
      tick();
      checkOutput("region_exc", {31'b0, bus.exc_valid}, {31'b0, !vecs[i].legal});
      checkOutput("region_mvalid", {31'b0, bus.m_valid}, {31'b0, vecs[i].legal});
    end
    idle(1'b1);
    tick();

    // Mixed traffic checked against the model every cycle
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0: a = $urandom_range(0, 32'h2FFF);
        1: a = 32'h0000_7F00 + $urandom_range(0, 15);
        2: a = 32'h0000_7F10 + $urandom_range(0, 15);
        3: a = 32'h0000_7F20 + $urandom_range(0, 7);
        4: a = 32'h0000_2FF8 + $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      tick();
    end
    idle(1'b1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/store_pack.md
STORE_PACK -- requirements
Module: store_pack

Interface
REQ-001 store_pack SHALL expose: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 req_valid  input  1  store request present.
REQ-004 req_ready  output  1  store_pack can accept a request this cycle.
REQ-005 req_op  input  2  00=sw, 01=sh, 10=sb, 11=reserved.
REQ-006 req_addr  input  32  byte address of the store.
REQ-007 req_data  input  32  register value to store; low bits significant for sh/sb.
REQ-008 flush  input  1  pipeline flush; discards the pending store.
REQ-009 m_valid  output  1  formatted store pending toward memory/bridge.
REQ-010 m_ready  input  1  memory side accepts the store this cycle.
REQ-011 m_addr  output  32  word address {addr[31:2],2'b00}.
REQ-012 m_byteen  output  4  byte-lane write enables; bit i gates m_wdata[8i+7:8i].
REQ-013 m_wdata  output  32  lane-replicated write data.
REQ-014 exc_valid  output  1  one-cycle AdES pulse.
REQ-015 exc_code  output  5  constant 5'd5 (AdES) while exc_valid=1, else 0.
REQ-016 exc_badvaddr  output  32  faulting req_addr; holds last value when exc_valid=0.

Function
REQ-017 Request accepted SHALL mean req_valid && req_ready && !flush at a rising edge.
REQ-018 req_ready SHALL equal !m_valid || m_ready (single output register, pass-through on drain).
REQ-019 States SHALL be EMPTY (m_valid=0) and FULL (m_valid=1); EMPTY->FULL on legal accept; FULL->EMPTY on m_ready without a new legal accept; FULL->FULL on m_ready with a new legal accept (register reloaded); FULL holds all m_* outputs stable while m_ready=0.
REQ-020 Latency SHALL be one cycle: a legal accept at edge N drives m_valid=1 with formatted fields after edge N.
REQ-021 Lane rules SHALL be: sw byteen=1111, wdata=data; sh byteen=0011 if addr[1]=0 else 1100, wdata={data[15:0],data[15:0]}; sb byteen=0001<<addr[1:0], wdata={4{data[7:0]}}.
REQ-022 Legal regions SHALL be DM 0x0000_0000-0x0000_2FFF, TC0 0x0000_7F00-0x0000_7F0B, TC1 0x0000_7F10-0x0000_7F1B, IG 0x0000_7F20-0x0000_7F23 (full 32-bit compare).
REQ-023 An accepted request SHALL be illegal if: sw with addr[1:0]!=0; sh with addr[0]!=0; outside all regions; sh/sb to TC0/TC1; any store to TC offset 8 (COUNT, read-only); req_op=11.
REQ-024 An illegal accept SHALL NOT load or alter the output register; it SHALL produce exc_valid=1, exc_code=5, exc_badvaddr=req_addr for exactly the following cycle.
REQ-025 Illegal requests SHALL be accepted (consume req_valid) under the same req_ready rule as legal ones.
REQ-026 flush=1 SHALL clear m_valid next cycle unless m_valid && m_ready in that same cycle (transfer completes, then EMPTY); a request presented with flush SHALL be dropped with no exception.
REQ-027 exc_valid SHALL never be 1 in two consecutive cycles from one request; back-to-back illegal accepts yield back-to-back pulses with updated badvaddr.

Reset
REQ-028 reset=1 at a rising edge SHALL force m_valid=0, m_addr=0, m_byteen=0, m_wdata=0, exc_valid=0, exc_code=0, exc_badvaddr=0, discarding any pending store; reset SHALL take priority over flush, accept and m_ready.
REQ-029 req_ready SHALL read 1 during and after reset.

Verification
REQ-030 sb addr=0x0000_0103 data=0x1234_56AB, m_ready=1 -> next cycle m_valid=1, m_addr=0x0000_0100, byteen=1000, wdata=0xABAB_ABAB.
REQ-031 sh addr=0x0000_0202 data=0xFFFF_BEEF, m_ready=0 for 3 cycles -> byteen=1100, wdata=0xBEEF_BEEF stable, req_ready=0, then drains on m_ready=1.
REQ-032 sw addr=0x0000_7F08 -> exc_valid=1 one cycle, exc_code=5, badvaddr=0x0000_7F08, m_valid stays 0; sh addr=0x0000_0001 -> same pulse with badvaddr=0x0000_0001.
REQ-033 Back-to-back sw 0x0000_0000, 0x0000_0004 with m_ready=1 -> m_valid held 1 two cycles, m_addr 0x0 then 0x4, no bubble.
REQ-034 FULL with m_ready=0, assert flush -> m_valid=0 next cycle; same with m_ready=1 -> one transfer observed, then EMPTY.
REQ-035 FULL then reset=1 mid-operation -> all outputs 0 next cycle, req_ready=1.
